pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low; rst=0 resets the block immediately, independent of clk.
REQ-003 SHALL have inputs id_rs_addr and id_rt_addr, each ASIZE bits: source register addresses of the instruction in ID.
REQ-004 SHALL have inputs id_uses_rs and id_uses_rt, each 1 bit: the corresponding ID source is actually read.
REQ-005 SHALL have inputs ex_waddr (ASIZE), ex_write_en (1) and ex_mem_to_reg (1): destination, write-enable and load flag of the instruction in EX.
REQ-006 SHALL have inputs mem_waddr (ASIZE) and mem_write_en (1): destination and write-enable of the instruction in MEM.
REQ-007 SHALL have inputs wb_waddr (ASIZE) and wb_write_en (1): destination and write-enable of the instruction in WB.
REQ-008 SHALL have input br_taken, 1 bit: branch resolved taken in EX.
REQ-009 SHALL have inputs dmem_req and dmem_ready, 1 bit each: data-memory access in MEM, and completion of that access.
REQ-010 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: load enables for the PC and each pipeline register.
REQ-011 SHALL have outputs ifid_flush and idex_flush, 1 bit each: force the corresponding pipeline register to a bubble.
REQ-012 SHALL have outputs state (2 bits), stall_cnt (16 bits) and flush_cnt (16 bits).

Function
REQ-013 SHALL implement a registered FSM with states RUN=2'd0, MWAIT=2'd1 and HAZ=2'd2.
REQ-014 SHALL derive all enable and flush outputs combinationally from the current state and inputs, in strict priority: memory wait, then branch, then hazard, then normal.
REQ-015 Memory wait: when dmem_req=1 and dmem_ready=0, all five enables SHALL be 0 and both flushes 0; the next state SHALL be MWAIT.
REQ-016 In MWAIT, the block SHALL hold the freeze of REQ-015 until dmem_ready=1; in that cycle all enables SHALL be 1 and the next state SHALL be RUN.
REQ-017 Branch: when br_taken=1 and memory wait is not active, all enables SHALL be 1 with ifid_flush=1 and idex_flush=1; flush_cnt SHALL increment; the next state SHALL be RUN.
REQ-018 Hazard: when hazard (REQ-021) is true and neither memory wait nor branch is active, pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1 and memwb_en=1; the next state SHALL be HAZ.
REQ-019 HAZ SHALL re-evaluate hazard each cycle: it stays in HAZ while the hazard persists and returns to RUN when it clears.
REQ-020 In RUN with no event active, all enables SHALL be 1 and both flushes 0.
REQ-021 A match SHALL require a nonzero address, the corresponding id_uses_* bit set, and the producer's write_en set; address 0 never causes a hazard.
REQ-022 stall_cnt SHALL increment on every cycle in which pc_en=0.
REQ-023 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF.
REQ-024 When br_taken and hazard occur in the same cycle, the branch SHALL win: no stall, and stall_cnt does not increment.

Reset
REQ-025 While rst=0, the FSM SHALL be in RUN, stall_cnt and flush_cnt SHALL be 0, all enables 0 and both flushes 0.
REQ-026 rst asserted while in MWAIT or HAZ SHALL abort that state immediately.
REQ-027 The first rising clk edge after rst deasserts SHALL evaluate normally from RUN.

Configuration
REQ-028 Macro FWD_EN SHALL select the hazard rule.
REQ-029 With FWD_EN defined, hazard is a load-use hazard only: an ID source matches ex_waddr while ex_mem_to_reg=1; mem and wb destinations are ignored.
REQ-030 Without FWD_EN, hazard is any ID source matching ex_waddr, mem_waddr or wb_waddr, each under its own write_en.

Verification
REQ-031 FWD_EN, EX load to r3, ID reads rs=r3 -> exactly one cycle with pc_en=0 and idex_flush=1; stall_cnt=1; state RUN next.
REQ-032 No FWD_EN, ID reads r5, r5 pending in EX, then MEM, then WB -> three consecutive stall cycles; stall_cnt=3.
REQ-033 dmem_req=1 with dmem_ready low for 4 cycles -> all enables 0 for 4 cycles and state=MWAIT; enables return to 1 when ready rises; stall_cnt=4.
REQ-034 br_taken and a load-use hazard in the same cycle -> both flushes 1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
REQ-035 rst pulled low mid-MWAIT -> outputs and counters 0 and state RUN immediately, without waiting for clk.
REQ-036 Preload stall_cnt to 16'hFFFE, then 3 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage in-order pipeline.
//
// Purpose: drives the PC and pipeline-register load enables and bubble flushes
// from data-memory waits, taken branches and register data hazards, and keeps
// saturating stall/flush event counters.
//
// Configuration: define FWD_EN when the datapath has full forwarding; the
// hazard rule then reduces to load-use against EX. Left undefined, any
// pending write in EX, MEM or WB to an ID source causes a stall.
//
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   id_rs_addr/id_rt_addr        ID source addresses (ASIZE)
//   id_uses_rs/id_uses_rt        ID source actually read
//   ex_waddr/ex_write_en/ex_mem_to_reg   EX destination, write enable, load flag
//   mem_waddr/mem_write_en       MEM destination and write enable
//   wb_waddr/wb_write_en         WB destination and write enable
//   br_taken                     branch resolved taken in EX
//   dmem_req/dmem_ready          data-memory access in MEM / access complete
//   pc_en..memwb_en              load enables (combinational)
//   ifid_flush/idex_flush        bubble injection (combinational)
//   state                        FSM state: RUN=0, MWAIT=1, HAZ=2
//   stall_cnt/flush_cnt          saturating counters of stall / branch-flush cycles
module pipeline_ctrl #(
  parameter int unsigned ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs_addr,
  input  logic [ASIZE-1:0] id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_write_en,
  input  logic             ex_mem_to_reg,
  input  logic [ASIZE-1:0] mem_waddr,
  input  logic             mem_write_en,
  input  logic [ASIZE-1:0] wb_waddr,
  input  logic             wb_write_en,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HAZ   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic hazard;
  logic freeze;
  logic mem_release;

  // A source depends on a producer only if it is really read, is not r0,
  // and the producer really writes that register.
  function automatic logic src_match(input logic             uses,
                                     input logic [ASIZE-1:0] src,
                                     input logic [ASIZE-1:0] dst,
                                     input logic             we);
    return uses && (src != '0) && we && (src == dst);
  endfunction

  // Hazard detection
`ifdef FWD_EN
  // Forwarding covers everything except a load result needed in the next cycle.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_waddr, mem_write_en, wb_waddr, wb_write_en};

  always_comb begin
    hazard = 1'b0;
    hazard = ex_mem_to_reg &&
             (src_match(id_uses_rs, id_rs_addr, ex_waddr, ex_write_en) ||
              src_match(id_uses_rt, id_rt_addr, ex_waddr, ex_write_en));
  end
`else
  // No forwarding: any in-flight write to a source must retire first.
  always_comb begin
    hazard = 1'b0;
    hazard = src_match(id_uses_rs, id_rs_addr, ex_waddr,  ex_write_en)  ||
             src_match(id_uses_rs, id_rs_addr, mem_waddr, mem_write_en) ||
             src_match(id_uses_rs, id_rs_addr, wb_waddr,  wb_write_en)  ||
             src_match(id_uses_rt, id_rt_addr, ex_waddr,  ex_write_en)  ||
             src_match(id_uses_rt, id_rt_addr, mem_waddr, mem_write_en) ||
             src_match(id_uses_rt, id_rt_addr, wb_waddr,  wb_write_en);
  end
`endif

  // Freeze while a memory access is outstanding; MWAIT keeps the freeze until ready.
  assign freeze      = !dmem_ready && (dmem_req || (state_q == ST_MWAIT));
  assign mem_release = (state_q == ST_MWAIT) && dmem_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: memory wait > MWAIT release > branch > hazard > run
  always_comb begin
    state_d = state_q;
    if (freeze) begin
      state_d = ST_MWAIT;
    end else if (mem_release || br_taken) begin
      state_d = ST_RUN;
    end else if (hazard) begin
      state_d = ST_HAZ;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output logic; everything is held low while reset is asserted
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst && !freeze) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (hazard && !mem_release) begin
        // Hold IF/ID and PC, send a bubble into EX, let older stages drain.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Saturating event counters; ifid_flush is only ever raised by a taken branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (ifid_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CW'(1);
      end
    end
  end

  assign state = 2'(state_q);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stimulus pushes hand-computed expectations
// into a queue, a monitor pops and compares on each sample strobe.
module tb_pipeline_ctrl;

  localparam int unsigned ASIZE = 5;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] HZ   = 5'b00111;
  localparam logic [1:0] RUN = 2'd0, MWAIT = 2'd1, HAZ = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ASIZE-1:0] id_rs_addr, id_rt_addr, ex_waddr, mem_waddr, wb_waddr;
  logic id_uses_rs, id_uses_rt, ex_write_en, ex_mem_to_reg, mem_write_en, wb_write_en;
  logic br_taken, dmem_req, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0] state;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.ASIZE(ASIZE)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_waddr(ex_waddr), .ex_write_en(ex_write_en), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_waddr(mem_waddr), .mem_write_en(mem_write_en),
    .wb_waddr(wb_waddr), .wb_write_en(wb_write_en),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [1:0] fl;
    logic [1:0] st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int n_total = 0;
  int n_pass  = 0;

  // Monitor: compares the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    logic [40:0] act, req;
    forever begin
      @(sample_ev);
      n_total++;
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             state, stall_cnt, flush_cnt};
      if (exp_q.size() == 0) begin
        $display("FAIL sample_without_expectation actual=%h", act);
      end else begin
        e   = exp_q.pop_front();
        req = {e.en, e.fl, e.st, e.sc, e.fc};
        if (act === req) begin
          n_pass++;
        end else begin
          $display("FAIL %s en/fl/st/sc/fc actual=%b/%b/%0d/%h/%h required=%b/%b/%0d/%h/%h",
                   e.name, act[40:36], act[35:34], act[33:32], act[31:16], act[15:0],
                   e.en, e.fl, e.st, e.sc, e.fc);
        end
      end
    end
  end

  task automatic idle();
    id_rs_addr = '0; id_rt_addr = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_waddr = '0; ex_write_en = 1'b0; ex_mem_to_reg = 1'b0;
    mem_waddr = '0; mem_write_en = 1'b0; wb_waddr = '0; wb_write_en = 1'b0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk(input string nm, input logic [4:0] en, input logic [1:0] fl,
                     input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.name = nm; e.en = en; e.fl = fl; e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    #1;
    ->sample_ev;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    chk("reset_hold", NONE, 2'b00, RUN, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    chk("reset_initial", NONE, 2'b00, RUN, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Normal flow and the non-matching cases
    nxt(); chk("run_idle", ALL, 2'b00, RUN, 16'd0, 16'd0);
    nxt(); id_rs_addr = 5'd0; id_uses_rs = 1'b1; ex_waddr = 5'd0; ex_write_en = 1'b1; ex_mem_to_reg = 1'b1;
    chk("r0_no_hazard", ALL, 2'b00, RUN, 16'd0, 16'd0);
    nxt(); id_rs_addr = 5'd3; id_uses_rs = 1'b0; ex_waddr = 5'd3; ex_write_en = 1'b1; ex_mem_to_reg = 1'b1;
    chk("unused_src_no_hazard", ALL, 2'b00, RUN, 16'd0, 16'd0);
    nxt(); id_rs_addr = 5'd3; id_uses_rs = 1'b1; ex_waddr = 5'd3; ex_write_en = 1'b0; ex_mem_to_reg = 1'b1;
    chk("no_we_no_hazard", ALL, 2'b00, RUN, 16'd0, 16'd0);

    // Load-use: exactly one stall cycle
    nxt(); id_rs_addr = 5'd3; id_uses_rs = 1'b1; ex_waddr = 5'd3; ex_write_en = 1'b1; ex_mem_to_reg = 1'b1;
    chk("loaduse_stall", HZ, 2'b01, RUN, 16'd0, 16'd0);
    nxt(); chk("loaduse_after", ALL, 2'b00, HAZ, 16'd1, 16'd0);
    nxt(); chk("loaduse_run", ALL, 2'b00, RUN, 16'd1, 16'd0);

    // r5 pending in EX, MEM, WB (ALU result, not a load)
    do_reset();
    nxt(); id_rs_addr = 5'd5; id_uses_rs = 1'b1; ex_waddr = 5'd5; ex_write_en = 1'b1;
    chk("r5_ex", FWD ? ALL : HZ, FWD ? 2'b00 : 2'b01, RUN, 16'd0, 16'd0);
    nxt(); id_rs_addr = 5'd5; id_uses_rs = 1'b1; mem_waddr = 5'd5; mem_write_en = 1'b1;
    chk("r5_mem", FWD ? ALL : HZ, FWD ? 2'b00 : 2'b01, FWD ? RUN : HAZ, FWD ? 16'd0 : 16'd1, 16'd0);
    nxt(); id_rs_addr = 5'd5; id_uses_rs = 1'b1; wb_waddr = 5'd5; wb_write_en = 1'b1;
    chk("r5_wb", FWD ? ALL : HZ, FWD ? 2'b00 : 2'b01, FWD ? RUN : HAZ, FWD ? 16'd0 : 16'd2, 16'd0);
    nxt(); chk("r5_clear", ALL, 2'b00, FWD ? RUN : HAZ, FWD ? 16'd0 : 16'd3, 16'd0);
    nxt(); chk("r5_run", ALL, 2'b00, RUN, FWD ? 16'd0 : 16'd3, 16'd0);

    // rt source against a WB write
    do_reset();
    nxt(); id_rt_addr = 5'd7; id_uses_rt = 1'b1; wb_waddr = 5'd7; wb_write_en = 1'b1;
    chk("rt_wb", FWD ? ALL : HZ, FWD ? 2'b00 : 2'b01, RUN, 16'd0, 16'd0);
    nxt(); chk("rt_wb_after", ALL, 2'b00, FWD ? RUN : HAZ, FWD ? 16'd0 : 16'd1, 16'd0);

    // Memory wait for 4 cycles, branch inside the wait is ignored
    do_reset();
    nxt(); dmem_req = 1'b1; chk("mw0", NONE, 2'b00, RUN, 16'd0, 16'd0);
    nxt(); dmem_req = 1'b1; chk("mw1", NONE, 2'b00, MWAIT, 16'd1, 16'd0);
    nxt(); dmem_req = 1'b1; br_taken = 1'b1; chk("mw2_br", NONE, 2'b00, MWAIT, 16'd2, 16'd0);
    nxt(); dmem_req = 1'b1; chk("mw3", NONE, 2'b00, MWAIT, 16'd3, 16'd0);
    nxt(); dmem_req = 1'b1; dmem_ready = 1'b1; chk("mw_release", ALL, 2'b00, MWAIT, 16'd4, 16'd0);
    nxt(); chk("mw_run", ALL, 2'b00, RUN, 16'd4, 16'd0);

    // Branch and load-use together: branch wins
    do_reset();
    nxt(); br_taken = 1'b1; id_rs_addr = 5'd3; id_uses_rs = 1'b1;
    ex_waddr = 5'd3; ex_write_en = 1'b1; ex_mem_to_reg = 1'b1;
    chk("br_vs_hazard", ALL, 2'b11, RUN, 16'd0, 16'd0);
    nxt(); chk("br_after", ALL, 2'b00, RUN, 16'd0, 16'd1);
    nxt(); br_taken = 1'b1; chk("br_second", ALL, 2'b11, RUN, 16'd0, 16'd1);
    nxt(); chk("br_second_after", ALL, 2'b00, RUN, 16'd0, 16'd2);

    // Asynchronous reset in the middle of MWAIT
    do_reset();
    nxt(); dmem_req = 1'b1; chk("arst_mw0", NONE, 2'b00, RUN, 16'd0, 16'd0);
    nxt(); dmem_req = 1'b1; chk("arst_mw1", NONE, 2'b00, MWAIT, 16'd1, 16'd0);
    #1; rst = 1'b0;
    chk("arst_immediate", NONE, 2'b00, RUN, 16'd0, 16'd0);
    @(negedge clk); rst = 1'b1;
    chk("arst_first_eval", NONE, 2'b00, RUN, 16'd0, 16'd0);
    @(negedge clk); chk("arst_second_eval", NONE, 2'b00, MWAIT, 16'd1, 16'd0);

    // stall_cnt saturation: run up to FFFE, then three more stalls
    do_reset();
    nxt(); dmem_req = 1'b1;
    repeat (65533) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sat_%0d", k), NONE, 2'b00, MWAIT, (k == 0) ? 16'hFFFE : 16'hFFFF, 16'd0);
    end
    @(negedge clk); dmem_ready = 1'b1; chk("sat_release", ALL, 2'b00, MWAIT, 16'hFFFF, 16'd0);
    nxt(); chk("sat_run", ALL, 2'b00, RUN, 16'hFFFF, 16'd0);

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
